// File: rtl/alu_mc.sv
// alu_mc: single-cycle ALU with a multi-cycle shift-add multiplier.
//
// Handshake: start is sampled on a rising edge only while busy = 0
// (FSM in IDLE); requests seen while busy = 1 are dropped. Every accepted
// request produces exactly one done pulse, one cycle wide, in the cycle
// where result/zero/ovf first show the new value. No backpressure exists.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       con,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   sft_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam logic [3:0] OP_MUL = 4'd12;

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   step_acc;

    // Combinational single-cycle operations and their signed overflow.
    always_comb begin
        sum     = op1 + op2;
        diff    = op1 - op2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (con)
            4'd1: begin
                alu_res = sum;
                alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            4'd2: begin
                alu_res = diff;
                alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            4'd3:    alu_res = op1 & op2;
            4'd4:    alu_res = op1 | op2;
            4'd5:    alu_res = op1 << sft_amt;
            4'd6:    alu_res = op1 >> sft_amt;
            4'd7:    alu_res = $unsigned($signed(op1) >>> sft_amt);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            4'd10:   alu_res = op1 ^ op2;
            4'd11:   alu_res = ~(op1 | op2);
            default: alu_res = '0;
        endcase
    end

    // Next-state logic: request acceptance in IDLE, one shift-add step per MUL cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        step_acc = acc_q + (mplr_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (con == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        mcand_d = op1;
                        mplr_d  = op2;
                        acc_d   = '0;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d   = step_acc;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d = step_acc;
                    zero_d   = (step_acc == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == MUL);
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit instance checked every cycle against a
// behavioural model, plus an 8-bit instance with directed checks.
module tb_alu_mc;

    localparam logic [3:0] C_NOP = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2, C_AND = 4'd3;
    localparam logic [3:0] C_OR = 4'd4, C_SLL = 4'd5, C_SRL = 4'd6, C_SRA = 4'd7;
    localparam logic [3:0] C_SLT = 4'd8, C_SLTU = 4'd9, C_XOR = 4'd10, C_NOR = 4'd11;
    localparam logic [3:0] C_MUL = 4'd12;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // 32-bit DUT signals
    logic        start = 1'b0;
    logic [3:0]  con = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [4:0]  sft_amt = '0;
    logic        busy, done, zero, ovf, state_dbg;
    logic [31:0] result;

    // 8-bit DUT signals
    logic        s8_start = 1'b0;
    logic [3:0]  s8_con = '0;
    logic [7:0]  s8_op1 = '0, s8_op2 = '0;
    logic [2:0]  s8_sft = '0;
    logic        s8_busy, s8_done, s8_zero, s8_ovf, s8_state;
    logic [7:0]  s8_result;

    alu_mc #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .con(con), .op1(op1), .op2(op2),
        .sft_amt(sft_amt), .busy(busy), .done(done), .result(result), .zero(zero),
        .ovf(ovf), .state_dbg(state_dbg)
    );

    alu_mc #(.WIDTH(8), .SHW(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .con(s8_con), .op1(s8_op1), .op2(s8_op2),
        .sft_amt(s8_sft), .busy(s8_busy), .done(s8_done), .result(s8_result), .zero(s8_zero),
        .ovf(s8_ovf), .state_dbg(s8_state)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU written from the opcode table with wide signed arithmetic.
    function automatic void spec_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] s, output logic [31:0] r, output logic v);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        v = 1'b0;
        case (c)
            C_ADD:  begin t = sa + sb; r = t[31:0]; v = (t > MAXS) || (t < MINS); end
            C_SUB:  begin t = sa - sb; r = t[31:0]; v = (t > MAXS) || (t < MINS); end
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_SLL:  r = a << s;
            C_SRL:  r = a >> s;
            C_SRA:  r = $unsigned($signed(a) >>> s);
            C_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            C_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            C_XOR:  r = a ^ b;
            C_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
    endfunction

    // Behavioural model of the 32-bit instance: a multiply is just a
    // countdown to a precomputed product.
    logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1, m_ovf = 1'b0;
    logic [31:0] m_result = '0, m_prod = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] r;
        logic v;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_zero = 1'b1; m_ovf = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_result = m_prod; m_zero = (m_prod == 0); m_ovf = 1'b0;
                    m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                if (con == C_MUL) begin
                    m_prod = 32'(64'(op1) * 64'(op2));
                    m_left = 32;
                    m_busy = 1'b1;
                end else begin
                    spec_alu(con, op1, op2, sft_amt, r, v);
                    m_result = r; m_zero = (r == 0); m_ovf = v; m_done = 1'b1;
                end
            end
        end
    end

    // Scoreboard compare on the falling edge, every cycle.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("result", 64'(result), 64'(m_result));
            chk("zero", 64'(zero), 64'(m_zero));
            chk("ovf", 64'(ovf), 64'(m_ovf));
            chk("state_dbg", 64'(state_dbg), 64'(m_busy));
        end
    end

    // Driver: present a request and return #2 after the edge that samples it.
    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        start = 1'b1; con = c; op1 = a; op2 = b; sft_amt = s;
        @(posedge clk); #2;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic drive8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        s8_start = 1'b1; s8_con = c; s8_op1 = a; s8_op2 = b; s8_sft = '0;
        @(posedge clk); #2;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_k;
        int n_busy;

        // Reset
        #1 rst_n = 1'b0;
        #2;
        cmp_on = 1'b1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst zero", 64'(zero), 64'd1);
        chk("rst ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset accepts: signed add overflow
        drive(C_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("add done", 64'(done), 64'd1);
        chk("add result", 64'(result), 64'h8000_0000);
        chk("add ovf", 64'(ovf), 64'd1);
        chk("add zero", 64'(zero), 64'd0);

        // Back-to-back sub then sra
        drive(C_SUB, 32'd5, 32'd5, 5'd0);
        chk("sub result", 64'(result), 64'd0);
        chk("sub zero", 64'(zero), 64'd1);
        chk("sub ovf", 64'(ovf), 64'd0);
        chk("sub done", 64'(done), 64'd1);
        drive(C_SRA, 32'h8000_0000, 32'h0000_1234, 5'd4);
        chk("sra result", 64'(result), 64'hF800_0000);
        chk("sra done", 64'(done), 64'd1);

        // Signed vs unsigned compare
        drive(C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt result", 64'(result), 64'd1);
        drive(C_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("sltu result", 64'(result), 64'd0);

        // Remaining opcodes and boundaries (model checks each cycle)
        drive(C_SLL, 32'hA5A5_0001, 32'hFFFF_FFFF, 5'd0);
        chk("sll zero amt", 64'(result), 64'hA5A5_0001);
        drive(C_SLL, 32'd3, 32'd0, 5'd31);
        chk("sll 31", 64'(result), 64'h8000_0000);
        drive(C_SRL, 32'h8000_0000, 32'd7, 5'd31);
        chk("srl 31", 64'(result), 64'd1);
        drive(C_SUB, 32'h8000_0000, 32'd1, 5'd0);
        chk("sub ovf result", 64'(result), 64'h7FFF_FFFF);
        chk("sub ovf flag", 64'(ovf), 64'd1);
        drive(C_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0);
        chk("add neg wrap zero", 64'(zero), 64'd1);
        drive(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        drive(C_OR, 32'hF000_0000, 32'h0000_000F, 5'd0);
        drive(C_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        chk("xor result", 64'(result), 64'hF0F0_0F0F);
        drive(C_NOR, 32'd0, 32'd0, 5'd0);
        chk("nor result", 64'(result), 64'hFFFF_FFFF);
        drive(4'd13, 32'h1234_5678, 32'h1, 5'd3);
        chk("op13 result", 64'(result), 64'd0);
        drive(C_NOP, 32'hDEAD_BEEF, 32'h1, 5'd3);
        drive(C_ADD, 32'd100, 32'hFFFF_FFFF, 5'd0);
        idle_cycle();
        chk("idle done low", 64'(done), 64'd0);
        chk("idle result held", 64'(result), 64'd99);

        // Multiply with ignored starts at cycles 3 and 10
        drive(C_MUL, 32'h0001_0003, 32'h0000_0005, 5'd0);
        n_busy = busy ? 1 : 0;
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3 || k == 10) begin
                start = 1'b1; con = C_ADD;
                op1 = $urandom; op2 = $urandom; sft_amt = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #2;
            if (busy) n_busy++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        chk("mul latency", 64'(done_k), 64'd32);
        chk("mul busy cycles", 64'(n_busy), 64'd32);
        chk("mul result", 64'(result), 64'h0005_000F);
        chk("mul ovf", 64'(ovf), 64'd0);
        idle_cycle();
        chk("mul done one cycle", 64'(done), 64'd0);

        // Reset during multiply aborts without done
        drive(C_MUL, 32'h0000_1234, 32'h0000_5678, 5'd0);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort zero", 64'(zero), 64'd1);
        chk("abort done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_ADD, 32'd2, 32'd3, 5'd0);
        chk("post-abort add", 64'(result), 64'd5);
        chk("post-abort done", 64'(done), 64'd1);
        idle_cycle();

        // 8-bit instance
        drive8(C_ADD, 8'd1, 8'd1);
        chk("w8 add", 64'(s8_result), 64'd2);
        chk("w8 add zero", 64'(s8_zero), 64'd0);
        drive8(C_MUL, 8'h10, 8'h10);
        s8_start = 1'b0;
        done_k = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #2;
            if (s8_done) begin
                done_k = k;
                break;
            end
        end
        chk("w8 mul latency", 64'(done_k), 64'd8);
        chk("w8 mul result", 64'(s8_result), 64'd0);
        chk("w8 mul zero", 64'(s8_zero), 64'd1);
        drive8(C_MUL, 8'h0D, 8'h0B);
        s8_start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("w8 mul2 done", 64'(s8_done), 64'd1);
        chk("w8 mul2 result", 64'(s8_result), 64'h8F);
        drive8(4'd15, 8'hAB, 8'hCD);
        s8_start = 1'b0;
        chk("w8 op15 result", 64'(s8_result), 64'd0);
        chk("w8 op15 done", 64'(s8_done), 64'd1);
        chk("w8 op15 busy", 64'(s8_busy), 64'd0);
        @(posedge clk); #2;

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
